// File: rtl/sar_search4_if.sv
// sar_search4_if: handshake and comparator bundle between a search requester and the SAR controller
//   start  : request a search (requester -> controller)
//   probe  : trial value driven onto the comparator b operand
//   gt/lt/eq : comparator flags for a vs probe
//   busy/done/result/err : search status and recovered value
interface sar_search4_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] probe;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
  modport master (output start, gt, lt, eq, input probe, busy, done, result, err);
  modport slave  (input start, gt, lt, eq, output probe, busy, done, result, err);
endinterface

// File: rtl/sar_search4.sv
// sar_search4: successive-approximation search driving a combinational magnitude comparator
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.start  : begin a search (taken only in IDLE)
//   bus.probe  : trial value, 0 outside TEST
//   bus.gt/lt/eq : comparator answer for the current probe
//   bus.busy   : high during TEST
//   bus.done   : one-cycle end-of-search pulse
//   bus.result : recovered value, bus.err : inconsistent flags seen
module sar_search4 #(parameter int WIDTH = 4) (
  input  logic          clk,
  input  logic          rst_n,
  sar_search4_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] kept, trial, kept_nxt, result;
  logic [IW-1:0]    idx;
  logic             err, ok, last;
  // odd parity excluding all-three-high means exactly one flag is set
  assign ok       = ^{bus.gt, bus.lt, bus.eq} & ~(bus.gt & bus.lt & bus.eq);
  assign trial    = kept | (WIDTH'(1) << idx);
  assign kept_nxt = bus.gt ? trial : kept;
  assign last     = idx == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_comb
    nxt = state == IDLE ? (bus.start ? TEST : IDLE) :
          state == TEST ? ((!ok || bus.eq || last) ? DONE : TEST) : IDLE;
  always_comb begin
    bus.busy   = state == TEST;
    bus.done   = state == DONE;
    bus.probe  = state == TEST ? trial : '0;
    bus.result = result;
    bus.err    = err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kept   <= '0;
      idx    <= IW'(WIDTH - 1);
      result <= '0;
      err    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      kept   <= '0;
      idx    <= IW'(WIDTH - 1);
      result <= '0;
      err    <= 1'b0;
    end else if (state == TEST) begin
      if (!ok) begin
        err    <= 1'b1;
        result <= '0;
      end else if (bus.eq) begin
        result <= trial;
      end else begin
        kept <= kept_nxt;
        if (last) result <= kept_nxt;
        else      idx    <= idx - IW'(1);
      end
    end
endmodule

// File: tb/tb_sar_search4.sv
// tb_sar_search4: directed-vector bench for sar_search4 with a behavioural comparator on the a side
module tb_sar_search4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic       inj;
  int         vec = 0;
  int         miss = 0;
  logic [3:0] plog [8];
  int         n, done_cyc;
  logic [3:0] res_d;
  logic       err_d, overlap, done_after;

  sar_search4_if #(.WIDTH(4)) bus();
  sar_search4 #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  assign bus.gt = inj | (a > bus.probe);
  assign bus.lt = inj | (a < bus.probe);
  assign bus.eq = ~inj & (a == bus.probe);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_search(input logic [3:0] av);
    a = av;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    done_cyc = 1;
    overlap = 1'b0;
    while (!bus.done && done_cyc < 20) begin
      if (bus.busy && n < 8) begin
        plog[n] = bus.probe;
        n++;
      end
      tick();
      done_cyc++;
    end
    if (bus.busy && bus.done) overlap = 1'b1;
    res_d = bus.result;
    err_d = bus.err;
    tick();
    done_after = bus.done;
  endtask

  task automatic test_reset();
    vec++; if (bus.probe !== 4'd0) begin miss++; $display("FAIL reset_probe: got %h want 0", bus.probe); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec++; if (bus.done !== 1'b0) begin miss++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vec++; if (bus.result !== 4'd0) begin miss++; $display("FAIL reset_result: got %h want 0", bus.result); end
    vec++; if (bus.err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", bus.err); end
  endtask

  task automatic test_eq_first();
    do_search(4'd8);
    vec++; if (n !== 1) begin miss++; $display("FAIL a8_tests: got %0d want 1", n); end
    vec++; if (plog[0] !== 4'b1000) begin miss++; $display("FAIL a8_probe: got %b want 1000", plog[0]); end
    vec++; if (done_cyc !== 2) begin miss++; $display("FAIL a8_done_cycle: got %0d want 2", done_cyc); end
    vec++; if (res_d !== 4'd8) begin miss++; $display("FAIL a8_result: got %h want 8", res_d); end
    vec++; if (err_d !== 1'b0) begin miss++; $display("FAIL a8_err: got %b want 0", err_d); end
    vec++; if (done_after !== 1'b0) begin miss++; $display("FAIL a8_done_width: got %b want 0", done_after); end
    vec++; if (overlap !== 1'b0) begin miss++; $display("FAIL a8_busy_done_overlap: got %b want 0", overlap); end
  endtask

  task automatic test_a11();
    logic [3:0] exp_p [4] = '{4'b1000, 4'b1100, 4'b1010, 4'b1011};
    do_search(4'd11);
    vec++; if (n !== 4) begin miss++; $display("FAIL a11_tests: got %0d want 4", n); end
    for (int j = 0; j < 4; j++) begin
      vec++; if (plog[j] !== exp_p[j]) begin miss++; $display("FAIL a11_probe%0d: got %b want %b", j, plog[j], exp_p[j]); end
    end
    vec++; if (done_cyc !== 5) begin miss++; $display("FAIL a11_done_cycle: got %0d want 5", done_cyc); end
    vec++; if (res_d !== 4'd11) begin miss++; $display("FAIL a11_result: got %h want b", res_d); end
    vec++; if (bus.result !== 4'd11) begin miss++; $display("FAIL a11_result_hold: got %h want b", bus.result); end
  endtask

  task automatic test_zero();
    logic [3:0] exp_p [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_search(4'd0);
    vec++; if (n !== 4) begin miss++; $display("FAIL a0_tests: got %0d want 4", n); end
    for (int j = 0; j < 4; j++) begin
      vec++; if (plog[j] !== exp_p[j]) begin miss++; $display("FAIL a0_probe%0d: got %b want %b", j, plog[j], exp_p[j]); end
    end
    vec++; if (done_cyc !== 5) begin miss++; $display("FAIL a0_done_cycle: got %0d want 5", done_cyc); end
    vec++; if (res_d !== 4'd0) begin miss++; $display("FAIL a0_result: got %h want 0", res_d); end
    vec++; if (err_d !== 1'b0) begin miss++; $display("FAIL a0_err: got %b want 0", err_d); end
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 16; v++) begin
      logic [3:0] kp, t;
      logic [3:0] exp_p [4];
      int m;
      kp = 4'd0;
      m = 0;
      for (int i = 3; i >= 0; i--) begin
        t = kp | (4'd1 << i);
        exp_p[m] = t;
        m++;
        if (t == 4'(v)) break;
        if (4'(v) > t) kp = t;
      end
      do_search(4'(v));
      vec++; if (n !== m || n > 4) begin miss++; $display("FAIL ex%0d_tests: got %0d want %0d", v, n, m); end
      for (int j = 0; j < m; j++) begin
        vec++; if (plog[j] !== exp_p[j]) begin miss++; $display("FAIL ex%0d_probe%0d: got %b want %b", v, j, plog[j], exp_p[j]); end
      end
      vec++; if (res_d !== 4'(v)) begin miss++; $display("FAIL ex%0d_result: got %h want %h", v, res_d, 4'(v)); end
      vec++; if (err_d !== 1'b0) begin miss++; $display("FAIL ex%0d_err: got %b want 0", v, err_d); end
      vec++; if (done_cyc !== m + 1) begin miss++; $display("FAIL ex%0d_done_cycle: got %0d want %0d", v, done_cyc, m + 1); end
      vec++; if (overlap !== 1'b0) begin miss++; $display("FAIL ex%0d_overlap: got %b want 0", v, overlap); end
    end
  endtask

  task automatic test_back_to_back();
    do_search(4'd9);
    vec++; if (res_d !== 4'd9 || done_cyc !== 5) begin miss++; $display("FAIL b2b_first: got %h/%0d want 9/5", res_d, done_cyc); end
    do_search(4'd2);
    vec++; if (res_d !== 4'd2 || done_cyc !== 4) begin miss++; $display("FAIL b2b_second: got %h/%0d want 2/4", res_d, done_cyc); end
  endtask

  task automatic test_fault();
    a = 4'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    vec++; if (bus.probe !== 4'b1100) begin miss++; $display("FAIL fault_probe2: got %b want 1100", bus.probe); end
    inj = 1'b1;
    tick();
    inj = 1'b0;
    vec++; if (bus.done !== 1'b1) begin miss++; $display("FAIL fault_done: got %b want 1", bus.done); end
    vec++; if (bus.err !== 1'b1) begin miss++; $display("FAIL fault_err: got %b want 1", bus.err); end
    vec++; if (bus.result !== 4'd0) begin miss++; $display("FAIL fault_result: got %h want 0", bus.result); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL fault_busy: got %b want 0", bus.busy); end
    tick();
    vec++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin miss++; $display("FAIL fault_hold: got err %b done %b want 1 0", bus.err, bus.done); end
    do_search(4'd5);
    vec++; if (err_d !== 1'b0) begin miss++; $display("FAIL fault_clear_err: got %b want 0", err_d); end
    vec++; if (res_d !== 4'd5) begin miss++; $display("FAIL fault_next_result: got %h want 5", res_d); end
  endtask

  task automatic test_start_held();
    a = 4'd6;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    vec++; if (bus.done !== 1'b0 || bus.probe !== 4'b0110) begin miss++; $display("FAIL held_c3: got done %b probe %b want 0 0110", bus.done, bus.probe); end
    tick();
    vec++; if (bus.done !== 1'b1 || bus.result !== 4'd6) begin miss++; $display("FAIL held_done: got done %b result %h want 1 6", bus.done, bus.result); end
    tick();
    vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miss++; $display("FAIL held_idle: got busy %b done %b want 0 0", bus.busy, bus.done); end
    tick();
    vec++; if (bus.busy !== 1'b1 || bus.probe !== 4'b1000) begin miss++; $display("FAIL held_restart: got busy %b probe %b want 1 1000", bus.busy, bus.probe); end
    bus.start = 1'b0;
    for (int i = 0; i < 10 && !bus.done; i++) tick();
    vec++; if (bus.done !== 1'b1 || bus.result !== 4'd6) begin miss++; $display("FAIL held_second: got done %b result %h want 1 6", bus.done, bus.result); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic bad;
    a = 4'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    vec++; if (bus.probe !== 4'b1010) begin miss++; $display("FAIL rmid_probe3: got %b want 1010", bus.probe); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.probe !== 4'd0 || bus.busy !== 1'b0) begin miss++; $display("FAIL rmid_async: got probe %b busy %b want 0000 0", bus.probe, bus.busy); end
    vec++; if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.result !== 4'd0) begin miss++; $display("FAIL rmid_outputs: got done %b err %b result %h want 0 0 0", bus.done, bus.err, bus.result); end
    tick();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) bad = 1'b1;
    end
    vec++; if (bad !== 1'b0) begin miss++; $display("FAIL rmid_no_done: got %b want 0", bad); end
    do_search(4'd13);
    vec++; if (res_d !== 4'd13) begin miss++; $display("FAIL rmid_restart: got %h want d", res_d); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    a = 4'd0;
    inj = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_eq_first();
    test_a11();
    test_zero();
    test_exhaustive();
    test_back_to_back();
    test_fault();
    test_start_held();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
